// File: rtl/axi4_xbar_1to2.sv
// rtl/axi4_xbar_1to2.sv - AXI4 1-to-2 address-decoding crossbar (m0 = SRAM, m1 = device window)
// One outstanding read and one outstanding write, each with its own FSM.
module axi4_xbar_1to2 #(
    parameter logic [31:0] DEV_BASE = 32'ha000_0000,
    parameter logic [31:0] DEV_MASK = 32'hff00_0000
) (
    input  logic        clk,
    input  logic        reset,
    // upstream
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_awaddr,
    input  logic [3:0]  s_awid,
    input  logic [7:0]  s_awlen,
    input  logic [2:0]  s_awsize,
    input  logic [1:0]  s_awburst,
    input  logic        s_wvalid,
    output logic        s_wready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wlast,
    output logic        s_bvalid,
    input  logic        s_bready,
    output logic [1:0]  s_bresp,
    output logic [3:0]  s_bid,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    input  logic [3:0]  s_arid,
    input  logic [7:0]  s_arlen,
    input  logic [2:0]  s_arsize,
    input  logic [1:0]  s_arburst,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [1:0]  s_rresp,
    output logic [31:0] s_rdata,
    output logic        s_rlast,
    output logic [3:0]  s_rid,
    // m0: SRAM
    output logic        m0_awvalid,
    input  logic        m0_awready,
    output logic [31:0] m0_awaddr,
    output logic [3:0]  m0_awid,
    output logic [7:0]  m0_awlen,
    output logic [2:0]  m0_awsize,
    output logic [1:0]  m0_awburst,
    output logic        m0_wvalid,
    input  logic        m0_wready,
    output logic [31:0] m0_wdata,
    output logic [3:0]  m0_wstrb,
    output logic        m0_wlast,
    input  logic        m0_bvalid,
    output logic        m0_bready,
    input  logic [1:0]  m0_bresp,
    input  logic [3:0]  m0_bid,
    output logic        m0_arvalid,
    input  logic        m0_arready,
    output logic [31:0] m0_araddr,
    output logic [3:0]  m0_arid,
    output logic [7:0]  m0_arlen,
    output logic [2:0]  m0_arsize,
    output logic [1:0]  m0_arburst,
    input  logic        m0_rvalid,
    output logic        m0_rready,
    input  logic [1:0]  m0_rresp,
    input  logic [31:0] m0_rdata,
    input  logic        m0_rlast,
    input  logic [3:0]  m0_rid,
    // m1: device / MMIO
    output logic        m1_awvalid,
    input  logic        m1_awready,
    output logic [31:0] m1_awaddr,
    output logic [3:0]  m1_awid,
    output logic [7:0]  m1_awlen,
    output logic [2:0]  m1_awsize,
    output logic [1:0]  m1_awburst,
    output logic        m1_wvalid,
    input  logic        m1_wready,
    output logic [31:0] m1_wdata,
    output logic [3:0]  m1_wstrb,
    output logic        m1_wlast,
    input  logic        m1_bvalid,
    output logic        m1_bready,
    input  logic [1:0]  m1_bresp,
    input  logic [3:0]  m1_bid,
    output logic        m1_arvalid,
    input  logic        m1_arready,
    output logic [31:0] m1_araddr,
    output logic [3:0]  m1_arid,
    output logic [7:0]  m1_arlen,
    output logic [2:0]  m1_arsize,
    output logic [1:0]  m1_arburst,
    input  logic        m1_rvalid,
    output logic        m1_rready,
    input  logic [1:0]  m1_rresp,
    input  logic [31:0] m1_rdata,
    input  logic        m1_rlast,
    input  logic [3:0]  m1_rid
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

    r_state_t    r_state, r_next;
    w_state_t    w_state, w_next;

    logic        rsel, wsel;
    logic [31:0] ar_addr, aw_addr;
    logic [3:0]  ar_id, aw_id;
    logic [7:0]  ar_len, aw_len;
    logic [2:0]  ar_size, aw_size;
    logic [1:0]  ar_burst, aw_burst;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= R_IDLE;
            rsel     <= 1'b0;
            ar_addr  <= '0;
            ar_id    <= '0;
            ar_len   <= '0;
            ar_size  <= '0;
            ar_burst <= '0;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && s_arvalid) begin
                rsel     <= ((s_araddr & DEV_MASK) == DEV_BASE);
                ar_addr  <= s_araddr;
                ar_id    <= s_arid;
                ar_len   <= s_arlen;
                ar_size  <= s_arsize;
                ar_burst <= s_arburst;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state  <= W_IDLE;
            wsel     <= 1'b0;
            aw_addr  <= '0;
            aw_id    <= '0;
            aw_len   <= '0;
            aw_size  <= '0;
            aw_burst <= '0;
        end else begin
            w_state <= w_next;
            if (w_state == W_IDLE && s_awvalid) begin
                wsel     <= ((s_awaddr & DEV_MASK) == DEV_BASE);
                aw_addr  <= s_awaddr;
                aw_id    <= s_awid;
                aw_len   <= s_awlen;
                aw_size  <= s_awsize;
                aw_burst <= s_awburst;
            end
        end
    end

    // Payloads fan out to both ports; only valid/ready depend on the select.
    assign m0_araddr  = ar_addr;   assign m1_araddr  = ar_addr;
    assign m0_arid    = ar_id;     assign m1_arid    = ar_id;
    assign m0_arlen   = ar_len;    assign m1_arlen   = ar_len;
    assign m0_arsize  = ar_size;   assign m1_arsize  = ar_size;
    assign m0_arburst = ar_burst;  assign m1_arburst = ar_burst;
    assign m0_awaddr  = aw_addr;   assign m1_awaddr  = aw_addr;
    assign m0_awid    = aw_id;     assign m1_awid    = aw_id;
    assign m0_awlen   = aw_len;    assign m1_awlen   = aw_len;
    assign m0_awsize  = aw_size;   assign m1_awsize  = aw_size;
    assign m0_awburst = aw_burst;  assign m1_awburst = aw_burst;
    assign m0_wdata   = s_wdata;   assign m1_wdata   = s_wdata;
    assign m0_wstrb   = s_wstrb;   assign m1_wstrb   = s_wstrb;
    assign m0_wlast   = s_wlast;   assign m1_wlast   = s_wlast;

    assign s_rdata = rsel ? m1_rdata : m0_rdata;
    assign s_rresp = rsel ? m1_rresp : m0_rresp;
    assign s_rlast = rsel ? m1_rlast : m0_rlast;
    assign s_rid   = rsel ? m1_rid   : m0_rid;
    assign s_bresp = wsel ? m1_bresp : m0_bresp;
    assign s_bid   = wsel ? m1_bid   : m0_bid;

    // Idle-state readies are qualified by reset so they read 0 while held in reset.
    always_comb begin
        r_next     = r_state;
        s_arready  = 1'b0;
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        m0_rready  = 1'b0;
        m1_rready  = 1'b0;
        s_rvalid   = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_arready = reset;
                if (s_arvalid) r_next = R_ADDR;
            end
            R_ADDR: begin
                m0_arvalid = !rsel;
                m1_arvalid = rsel;
                if (rsel ? m1_arready : m0_arready) r_next = R_DATA;
            end
            R_DATA: begin
                s_rvalid  = rsel ? m1_rvalid : m0_rvalid;
                m0_rready = !rsel && s_rready;
                m1_rready = rsel && s_rready;
                if (s_rvalid && s_rready && s_rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_next     = w_state;
        s_awready  = 1'b0;
        s_wready   = 1'b0;
        s_bvalid   = 1'b0;
        m0_awvalid = 1'b0;
        m1_awvalid = 1'b0;
        m0_wvalid  = 1'b0;
        m1_wvalid  = 1'b0;
        m0_bready  = 1'b0;
        m1_bready  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_awready = reset;
                if (s_awvalid) w_next = W_ADDR;
            end
            W_ADDR: begin
                m0_awvalid = !wsel;
                m1_awvalid = wsel;
                if (wsel ? m1_awready : m0_awready) w_next = W_DATA;
            end
            W_DATA: begin
                m0_wvalid = !wsel && s_wvalid;
                m1_wvalid = wsel && s_wvalid;
                s_wready  = wsel ? m1_wready : m0_wready;
                if (s_wvalid && s_wready && s_wlast) w_next = W_RESP;
            end
            W_RESP: begin
                s_bvalid  = wsel ? m1_bvalid : m0_bvalid;
                m0_bready = !wsel && s_bready;
                m1_bready = wsel && s_bready;
                if (s_bvalid && s_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

endmodule
